// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the three-port RAM arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic {
    st_arb  = 1'b0,
    st_hold = 1'b1
  } arb_state_e;

  localparam int unsigned P_FETCH = 0;
  localparam int unsigned P_OPER  = 1;
  localparam int unsigned P_WR    = 2;

  // Round-robin successor of a one-hot winner; an empty grant maps to port 1.
  function automatic logic [1:0] next_ptr(logic [2:0] onehot);
    if (onehot[P_WR]) begin
      return 2'd0;
    end else if (onehot[P_OPER]) begin
      return 2'd2;
    end
    return 2'd1;
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// Three-way round-robin picker: first requester at or after ptr_i, one-hot result.
module rr_pick3 (
  input  logic [2:0] req_i,
  input  logic [1:0] ptr_i,
  output logic [2:0] gnt_o
);

  always_comb begin
    gnt_o = 3'b000;
    case (ptr_i)
      2'd1: begin
        if (req_i[1])      gnt_o = 3'b010;
        else if (req_i[2]) gnt_o = 3'b100;
        else if (req_i[0]) gnt_o = 3'b001;
      end
      2'd2: begin
        if (req_i[2])      gnt_o = 3'b100;
        else if (req_i[0]) gnt_o = 3'b001;
        else if (req_i[1]) gnt_o = 3'b010;
      end
      default: begin
        if (req_i[0])      gnt_o = 3'b001;
        else if (req_i[1]) gnt_o = 3'b010;
        else if (req_i[2]) gnt_o = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch, operand-read and result-write ports onto one single-port RAM,
// with bounded fetch hold, registered read-valid and a saturating contention counter.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned n        = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [2:0]   req,
  input  logic [n-1:0] addr0,
  input  logic [n-1:0] addr1,
  input  logic [n-1:0] addr2,
  input  logic [n-1:0] wdata2,
  output logic [2:0]   gnt,
  output logic [n-1:0] rdata,
  output logic [1:0]   rvalid,
  output logic         ram_en,
  output logic         ram_we,
  output logic [n-1:0] ram_addr,
  output logic [n-1:0] ram_wdata,
  input  logic [n-1:0] ram_rdata,
  output logic [7:0]   conflict_cnt
);

  localparam logic [3:0] MaxHoldC = 4'(MAX_HOLD);

  arb_state_e state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] hold_cnt_q, hold_cnt_d;
  logic [1:0] rvalid_q, rvalid_d;
  logic [7:0] conflict_cnt_q, conflict_cnt_d;

  logic [2:0] pick_arb, pick_exit;
  logic       hold_exit;
  logic       multi_req;

  rr_pick3 u_pick_arb (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (pick_arb)
  );

  // Leaving fetch hold always resumes round-robin from port 1.
  rr_pick3 u_pick_exit (
    .req_i (req),
    .ptr_i (2'd1),
    .gnt_o (pick_exit)
  );

  assign hold_exit = !req[P_FETCH] || ((hold_cnt_q == MaxHoldC) && (|req[2:1]));

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    gnt        = 3'b000;
    unique case (state_q)
      st_arb: begin
        gnt = pick_arb;
        if (gnt[P_FETCH]) begin
          state_d    = st_hold;
          hold_cnt_d = 4'd1;
          ptr_d      = next_ptr(gnt);
        end else if (|gnt) begin
          ptr_d = next_ptr(gnt);
        end
      end
      st_hold: begin
        if (hold_exit) begin
          gnt        = pick_exit;
          state_d    = st_arb;
          hold_cnt_d = 4'd0;
          // next_ptr of an empty grant is 1, matching the hold-exit restart point.
          ptr_d      = next_ptr(pick_exit);
        end else begin
          gnt[P_FETCH] = 1'b1;
          if (hold_cnt_q < MaxHoldC) begin
            hold_cnt_d = hold_cnt_q + 4'd1;
          end
        end
      end
    endcase
  end

  assign multi_req = (req[0] & req[1]) | (req[0] & req[2]) | (req[1] & req[2]);

  always_comb begin
    rvalid_d       = gnt[1:0] & req[1:0];
    conflict_cnt_d = conflict_cnt_q;
    if (multi_req && (conflict_cnt_q != 8'hFF)) begin
      conflict_cnt_d = conflict_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= st_arb;
      ptr_q          <= 2'd0;
      hold_cnt_q     <= 4'd0;
      rvalid_q       <= 2'b00;
      conflict_cnt_q <= 8'd0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      hold_cnt_q     <= hold_cnt_d;
      rvalid_q       <= rvalid_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign ram_en       = |gnt;
  assign ram_we       = gnt[P_WR];
  assign ram_addr     = ({n{gnt[P_FETCH]}} & addr0) | ({n{gnt[P_OPER]}} & addr1) |
                        ({n{gnt[P_WR]}} & addr2);
  assign ram_wdata    = ram_en ? wdata2 : '0;
  assign rdata        = ram_rdata;
  assign rvalid       = rvalid_q;
  assign conflict_cnt = conflict_cnt_q;

endmodule
